instr_fetch_ctrl: RTL and testbench
===================================

# instr_fetch_ctrl

Instruction fetch controller sequencing the 512×32 instruction ROM (combinational read, latency 0) for the processor core. Holds the program counter, drives the ROM address and registers each fetched word into a single output slot with a valid/ready handshake toward decode. Supports start/halt control, branch/jump redirect with flush, and PC wrap-around reporting.

## Interface
- ADDR_WIDTH, 9, ROM address width (512 words)
- DATA_WIDTH, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- clka  in  1  system clock, all state on rising edge
- rsta  in  1  reset, synchronous, active-high
- start  in  1  pulse: leave IDLE/HALT and begin fetching
- halt_req  in  1  pulse: stop fetching after current slot drains
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  ADDR_WIDTH  target address for redirect
- rom_addr  out  ADDR_WIDTH  ROM address, equals pc register
- rom_data  in  DATA_WIDTH  ROM read data for rom_addr, same cycle
- instr_out  out  DATA_WIDTH  registered instruction
- instr_pc  out  ADDR_WIDTH  address instr_out was fetched from
- instr_valid  out  1  instr_out holds an unconsumed instruction
- instr_ready  in  1  decode accepts instr_out this cycle
- pc_wrap  out  1  one-cycle pulse when pc advances from 511 to 0
- busy  out  1  high in RUN

## Operation
- States: IDLE, RUN, HALT. Reset -> IDLE.
- Reset values: pc=RESET_PC, rom_addr=RESET_PC, instr_out=0, instr_pc=0, instr_valid=0, pc_wrap=0, busy=0.
- IDLE: no fetch; start -> RUN. halt_req ignored.
- RUN: slot "free" when !instr_valid or instr_ready. If free: instr_out<=rom_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1. If not free: pc, slot held stable.
- Handshake transfer = instr_valid && instr_ready. instr_out/instr_pc must not change while instr_valid && !instr_ready (except on redirect flush).
- PC arithmetic: ADDR_WIDTH-bit modulo; 511+1 = 0 with pc_wrap pulsed the cycle after the increment edge; fetching continues.
- Redirect (any state, highest priority on pc and slot): pc<=redirect_pc, instr_valid<=0 (slot flushed regardless of instr_ready); no fetch that cycle; state unchanged.
- halt_req in RUN -> HALT; no fetch that cycle; pending slot kept valid until accepted, then instr_valid<=0.
- HALT: no fetch; start -> RUN with pc unchanged.
- Simultaneous: halt_req+start in RUN -> HALT; redirect+halt_req -> both applied (flush, new pc, HALT); start+redirect in IDLE/HALT -> RUN, pc=redirect_pc.
- rsta mid-operation overrides everything next edge; any pending instruction discarded.

## Timing
- Fetch latency: start at edge N -> RUN at N; first instr_valid=1 after edge N+1 carrying ROM[RESET_PC].
- Throughput: one instruction/cycle with instr_ready held high.
- Redirect at edge N -> instr_valid=0 after N; instruction at redirect_pc valid after N+1 (one bubble).
- Backpressure: instr_ready low -> zero fetches, pc frozen; resumes the cycle ready returns.
- busy registered, follows state.

## Structure
- Shared package fetch_pkg: state enum (IDLE, RUN, HALT), ADDR_WIDTH/DATA_WIDTH defaults, RESET_PC constant.
- ROM instance lives in the parent; this block only drives rom_addr / consumes rom_data.
- One sub-module natural: fetch_pc_reg (pc register with load/increment/wrap pulse).

## Test plan
- Reset then start, ready=1, ROM[k]=0x1000_0000+k -> instr_out 0x1000_0000, 0x1000_0001, ... on consecutive cycles, instr_pc 0,1,2.
- Backpressure: ready low 3 cycles while instr_pc=5 -> instr_out/instr_pc stable at addr 5, rom_addr=6 frozen; ready high -> addr 6 next.
- Redirect to 0x1F0 while slot valid at addr 8, ready=0 -> slot flushed, one bubble, next instr_pc=0x1F0.
- Redirect to 510, run -> instr_pc 510, 511, 0, 1; pc_wrap single pulse.
- halt_req with pending slot, ready=0 -> state HALT, slot held until ready, then instr_valid=0, no further fetch; start -> resumes at stored pc.
- rsta asserted in RUN with instr_valid=1 -> next cycle IDLE, instr_valid=0, rom_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller.
//   - fetch_state_e : controller state (IDLE, RUN, HALT)
//   - *_DEF         : default address/data widths and reset PC
package fetch_pkg;

  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int RESET_PC_DEF   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch controller.
//   clka, rsta : clock, synchronous active-high reset (pc <= RESET_PC)
//   load       : load load_pc (takes priority over inc)
//   load_pc    : redirect target
//   inc        : advance pc by one, modulo 2**ADDR_WIDTH
//   pc         : current program counter
//   wrap       : one-cycle pulse after an increment from the last address to 0
module fetch_pc_reg #(
  parameter int ADDR_WIDTH = 9,
  parameter int RESET_PC   = 0
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_pc,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  wrap
);

  localparam logic [ADDR_WIDTH-1:0] PC_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);

  always_ff @(posedge clka) begin
    if (rsta) begin
      pc   <= PC_RST;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        pc <= load_pc;
      end else if (inc) begin
        // Natural modulo overflow; flag it so software can see the wrap.
        pc   <= pc + PC_ONE;
        wrap <= (pc == PC_MAX);
      end
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller. Sequences a combinational instruction ROM,
// holding one fetched word in an output slot toward decode.
//   clka, rsta      : clock, synchronous active-high reset
//   start           : pulse, IDLE/HALT -> RUN
//   halt_req        : pulse, RUN -> HALT (pending slot drains normally)
//   redirect_valid  : branch/jump taken, load redirect_pc and flush the slot
//   redirect_pc     : redirect target
//   rom_addr        : ROM address (the pc register)
//   rom_data        : ROM word for rom_addr, same cycle
//   instr_out       : registered instruction
//   instr_pc        : address instr_out came from
//   instr_valid     : slot holds an unconsumed instruction
//   instr_ready     : decode accepts the slot this cycle
//   pc_wrap         : one-cycle pulse after pc advances from the last address to 0
//   busy            : registered, high while in RUN
//   state_dbg       : current controller state
//
// Handshake: a transfer happens on a rising edge where instr_valid and
// instr_ready are both high. While instr_valid is high and instr_ready low,
// instr_out/instr_pc hold steady; only a redirect may drop the slot early.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RESET_PC   = RESET_PC_DEF
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  pc_wrap,
  output logic                  busy,
  output fetch_state_e          state_dbg
);

  fetch_state_e          state_q;
  fetch_state_e          state_d;
  logic                  slot_free;
  logic                  fetch;
  logic                  take;
  logic [ADDR_WIDTH-1:0] pc;

  // State register; busy is registered from the next state so it tracks RUN
  // exactly without a combinational path from the inputs.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == ST_RUN);
    end
  end

  // Redirect never changes state on its own; halt wins over start in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)    state_d = ST_RUN;
      ST_RUN:  if (halt_req) state_d = ST_HALT;
      ST_HALT: if (start)    state_d = ST_RUN;
      default:               state_d = ST_IDLE;
    endcase
  end

  assign slot_free = !instr_valid || instr_ready;
  assign take      = instr_valid && instr_ready;
  // A cycle carrying halt or redirect fetches nothing: halt stops the stream,
  // and the current pc is about to be replaced on redirect.
  assign fetch     = (state_q == ST_RUN) && !halt_req && !redirect_valid && slot_free;

  fetch_pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clka    (clka),
    .rsta    (rsta),
    .load    (redirect_valid),
    .load_pc (redirect_pc),
    .inc     (fetch),
    .pc      (pc),
    .wrap    (pc_wrap)
  );

  assign rom_addr  = pc;
  assign state_dbg = state_q;

  // Output slot. Redirect flushes even an un-accepted word.
  always_ff @(posedge clka) begin
    if (rsta) begin
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (redirect_valid) begin
      instr_valid <= 1'b0;
    end else if (fetch) begin
      instr_out   <= rom_data;
      instr_pc    <= pc;
      instr_valid <= 1'b1;
    end else if (take) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;
  import fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clka = 1'b0;
  logic        rsta = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [8:0]  redirect_pc = '0;
  logic [8:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] instr_out;
  logic [8:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        pc_wrap;
  logic        busy;
  fetch_state_e state_dbg;

  always #5 clka = ~clka;

  logic [31:0] rom [512];
  assign rom_data = rom[rom_addr];

  instr_fetch_ctrl #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .RESET_PC(0)) dut (
    .clka           (clka),
    .rsta           (rsta),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .pc_wrap        (pc_wrap),
    .busy           (busy),
    .state_dbg      (state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  // Behavioural view: a mode (0 idle, 1 run, 2 halt), a program counter kept
  // as an integer modulo 512, and a queue holding the word owed to decode.
  int          m_state = 0;
  int          m_pc = 0;
  int          m_ipc = 0;
  bit          m_valid = 0;
  bit          m_wrap = 0;
  logic [31:0] exp_q[$];

  function automatic fetch_state_e st_of(int s);
    if (s == 1) return ST_RUN;
    if (s == 2) return ST_HALT;
    return ST_IDLE;
  endfunction

  task automatic model_step();
    bit fetch_now;
    if (rsta) begin
      m_state = 0; m_pc = 0; m_ipc = 0; m_valid = 0; m_wrap = 0;
      exp_q.delete();
      return;
    end
    fetch_now = (m_state == 1) && !halt_req && !redirect_valid && (!m_valid || instr_ready);
    m_wrap = fetch_now && (m_pc == 511);
    if (redirect_valid) begin
      m_valid = 0;
      exp_q.delete();
      m_pc = int'(redirect_pc);
    end else if (fetch_now) begin
      if (m_valid) void'(exp_q.pop_front());
      exp_q.push_back(rom[m_pc]);
      m_ipc = m_pc;
      m_valid = 1;
      m_pc = (m_pc + 1) % 512;
    end else if (m_valid && instr_ready) begin
      m_valid = 0;
      void'(exp_q.pop_front());
    end
    if ((m_state == 0 || m_state == 2) && start) m_state = 1;
    else if (m_state == 1 && halt_req) m_state = 2;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit s, input bit h, input bit rv, input int rpc, input bit rdy);
    start = s; halt_req = h; redirect_valid = rv; redirect_pc = 9'(rpc); instr_ready = rdy;
  endtask

  // Advance one clock; inputs are stable from 1 time unit after the previous
  // edge, outputs are sampled 1 time unit after this edge.
  task automatic cycle();
    model_step();
    @(posedge clka);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rsta = 1'b1;
    set_in(0, 0, 0, 0, 0);
    cycle(); cycle();
    rsta = 1'b0;
    n_checks++;
    if ({state_dbg, busy, instr_valid, pc_wrap, rom_addr} !== {ST_IDLE, 1'b0, 1'b0, 1'b0, 9'd0}) begin
      n_errors++;
      $display("FAIL reset_ctrl: got st=%0d busy=%b v=%b wrap=%b addr=%h", state_dbg, busy, instr_valid, pc_wrap, rom_addr);
    end
    n_checks++;
    if ({instr_out, instr_pc} !== {32'd0, 9'd0}) begin
      n_errors++;
      $display("FAIL reset_slot: got out=%h pc=%h exp 0/0", instr_out, instr_pc);
    end
    // halt_req is ignored in IDLE
    set_in(0, 1, 0, 0, 1);
    cycle();
    set_in(0, 0, 0, 0, 1);
    cycle();
    n_checks++;
    if ({state_dbg, instr_valid, rom_addr} !== {ST_IDLE, 1'b0, 9'd0}) begin
      n_errors++;
      $display("FAIL idle_halt: got st=%0d v=%b addr=%h exp IDLE/0/0", state_dbg, instr_valid, rom_addr);
    end
  endtask

  task automatic test_stream();
    set_in(1, 0, 0, 0, 1);
    cycle();
    set_in(0, 0, 0, 0, 1);
    n_checks++;
    if ({state_dbg, busy, instr_valid} !== {ST_RUN, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL start_latency: got st=%0d busy=%b v=%b exp RUN/1/0", state_dbg, busy, instr_valid);
    end
    for (int k = 0; k < 6; k++) begin
      cycle();
      n_checks++;
      if ({instr_valid, instr_pc, instr_out} !== {1'b1, 9'(k), 32'h1000_0000 + 32'(k)}) begin
        n_errors++;
        $display("FAIL stream[%0d]: got v=%b pc=%h out=%h exp pc=%h out=%h", k, instr_valid, instr_pc, instr_out, k, 32'h1000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_backpressure();
    // slot currently holds addr 5, pc is 6
    set_in(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_checks++;
      if ({instr_valid, instr_pc, instr_out, rom_addr} !== {1'b1, 9'd5, 32'h1000_0005, 9'd6}) begin
        n_errors++;
        $display("FAIL backpressure[%0d]: got v=%b pc=%h out=%h addr=%h exp 1/005/10000005/006", k, instr_valid, instr_pc, instr_out, rom_addr);
      end
    end
    set_in(0, 0, 0, 0, 1);
    for (int k = 6; k < 9; k++) begin
      cycle();
      n_checks++;
      if ({instr_valid, instr_pc, instr_out} !== {1'b1, 9'(k), 32'h1000_0000 + 32'(k)}) begin
        n_errors++;
        $display("FAIL resume[%0d]: got v=%b pc=%h out=%h", k, instr_valid, instr_pc, instr_out);
      end
    end
  endtask

  task automatic test_redirect();
    // slot valid at addr 8; redirect with ready low flushes it anyway
    set_in(0, 0, 1, 9'h1F0, 0);
    cycle();
    set_in(0, 0, 0, 0, 1);
    n_checks++;
    if ({instr_valid, rom_addr, state_dbg} !== {1'b0, 9'h1F0, ST_RUN}) begin
      n_errors++;
      $display("FAIL redirect_flush: got v=%b addr=%h st=%0d exp 0/1f0/RUN", instr_valid, rom_addr, state_dbg);
    end
    cycle();
    n_checks++;
    if ({instr_valid, instr_pc, instr_out} !== {1'b1, 9'h1F0, 32'h1000_01F0}) begin
      n_errors++;
      $display("FAIL redirect_target: got v=%b pc=%h out=%h exp 1/1f0/100001f0", instr_valid, instr_pc, instr_out);
    end
  endtask

  task automatic test_wrap();
    int exp_pcs [4] = '{510, 511, 0, 1};
    bit exp_wr  [4] = '{0, 1, 0, 0};
    int wraps = 0;
    set_in(0, 0, 1, 510, 1);
    cycle();
    set_in(0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      wraps += int'(pc_wrap);
      n_checks++;
      if ({instr_valid, instr_pc, pc_wrap} !== {1'b1, 9'(exp_pcs[k]), exp_wr[k]}) begin
        n_errors++;
        $display("FAIL wrap[%0d]: got v=%b pc=%h wrap=%b exp pc=%h wrap=%b", k, instr_valid, instr_pc, pc_wrap, exp_pcs[k], exp_wr[k]);
      end
    end
    n_checks++;
    if (wraps != 1) begin
      n_errors++;
      $display("FAIL wrap_count: got %0d exp 1", wraps);
    end
  endtask

  task automatic test_halt();
    // slot holds addr 1, pc is 2
    set_in(0, 1, 0, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0);
    n_checks++;
    if ({state_dbg, busy, instr_valid, instr_pc, rom_addr} !== {ST_HALT, 1'b0, 1'b1, 9'd1, 9'd2}) begin
      n_errors++;
      $display("FAIL halt_pending: got st=%0d busy=%b v=%b pc=%h addr=%h", state_dbg, busy, instr_valid, instr_pc, rom_addr);
    end
    cycle();
    n_checks++;
    if ({instr_valid, instr_pc} !== {1'b1, 9'd1}) begin
      n_errors++;
      $display("FAIL halt_hold: got v=%b pc=%h exp 1/001", instr_valid, instr_pc);
    end
    set_in(0, 0, 0, 0, 1);
    cycle(); cycle();
    n_checks++;
    if ({state_dbg, instr_valid, rom_addr} !== {ST_HALT, 1'b0, 9'd2}) begin
      n_errors++;
      $display("FAIL halt_drain: got st=%0d v=%b addr=%h exp HALT/0/002", state_dbg, instr_valid, rom_addr);
    end
    set_in(1, 0, 0, 0, 1);
    cycle();
    set_in(0, 0, 0, 0, 1);
    cycle();
    n_checks++;
    if ({state_dbg, instr_valid, instr_pc, instr_out} !== {ST_RUN, 1'b1, 9'd2, 32'h1000_0002}) begin
      n_errors++;
      $display("FAIL halt_resume: got st=%0d v=%b pc=%h out=%h", state_dbg, instr_valid, instr_pc, instr_out);
    end
  endtask

  task automatic test_reset_mid();
    rsta = 1'b1;
    cycle();
    rsta = 1'b0;
    n_checks++;
    if ({state_dbg, busy, instr_valid, rom_addr} !== {ST_IDLE, 1'b0, 1'b0, 9'd0}) begin
      n_errors++;
      $display("FAIL reset_mid: got st=%0d busy=%b v=%b addr=%h exp IDLE/0/0/000", state_dbg, busy, instr_valid, rom_addr);
    end
  endtask

  task automatic test_simultaneous();
    set_in(1, 0, 1, 9'h040, 1);
    cycle();
    n_checks++;
    if ({state_dbg, instr_valid, rom_addr} !== {ST_RUN, 1'b0, 9'h040}) begin
      n_errors++;
      $display("FAIL start_redirect: got st=%0d v=%b addr=%h exp RUN/0/040", state_dbg, instr_valid, rom_addr);
    end
    set_in(0, 0, 0, 0, 1);
    cycle();
    set_in(1, 1, 0, 0, 1);
    cycle();
    n_checks++;
    if ({state_dbg, busy, instr_valid, rom_addr} !== {ST_HALT, 1'b0, 1'b0, 9'h041}) begin
      n_errors++;
      $display("FAIL halt_start: got st=%0d busy=%b v=%b addr=%h exp HALT/0/0/041", state_dbg, busy, instr_valid, rom_addr);
    end
    set_in(1, 0, 0, 0, 1);
    cycle();
    set_in(0, 0, 0, 0, 1);
    cycle();
    set_in(0, 1, 1, 9'h100, 0);
    cycle();
    n_checks++;
    if ({state_dbg, instr_valid, rom_addr} !== {ST_HALT, 1'b0, 9'h100}) begin
      n_errors++;
      $display("FAIL redirect_halt: got st=%0d v=%b addr=%h exp HALT/0/100", state_dbg, instr_valid, rom_addr);
    end
    set_in(1, 0, 0, 0, 1);
    cycle();
    set_in(0, 0, 0, 0, 1);
    cycle();
    n_checks++;
    if ({instr_valid, instr_pc} !== {1'b1, 9'h100}) begin
      n_errors++;
      $display("FAIL redirect_halt_resume: got v=%b pc=%h exp 1/100", instr_valid, instr_pc);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 512; k++) rom[k] = $urandom;
    rsta = 1'b1;
    set_in(0, 0, 0, 0, 0);
    cycle();
    rsta = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rsta = ($urandom_range(0, 299) == 0);
      set_in($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
             $urandom_range(0, 19) == 0,
             ($urandom_range(0, 3) == 0) ? $urandom_range(505, 511) : $urandom_range(0, 511),
             $urandom_range(0, 9) < 7);
      // scoreboard: a transfer this edge must deliver the word owed to decode
      if (instr_valid && instr_ready && !redirect_valid && !rsta) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL rnd_xfer[%0d]: got out=%h with nothing expected", n, instr_out);
        end else if (instr_out !== exp_q[0]) begin
          n_errors++;
          $display("FAIL rnd_xfer[%0d]: got out=%h exp %h", n, instr_out, exp_q[0]);
        end
      end
      cycle();
      n_checks++;
      if ({state_dbg, busy, instr_valid, pc_wrap, rom_addr} !==
          {st_of(m_state), m_state == 1, m_valid, m_wrap, 9'(m_pc)}) begin
        n_errors++;
        $display("FAIL rnd_ctrl[%0d]: got st=%0d busy=%b v=%b wrap=%b addr=%h exp st=%0d v=%b wrap=%b addr=%h",
                 n, state_dbg, busy, instr_valid, pc_wrap, rom_addr, m_state, m_valid, m_wrap, m_pc);
      end
      if (m_valid) begin
        n_checks++;
        if (exp_q.size() != 1 || {instr_pc, instr_out} !== {9'(m_ipc), exp_q[0]}) begin
          n_errors++;
          $display("FAIL rnd_slot[%0d]: got pc=%h out=%h exp pc=%h (queue %0d)", n, instr_pc, instr_out, m_ipc, exp_q.size());
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int k = 0; k < 512; k++) rom[k] = 32'h1000_0000 + 32'(k);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
